// File: rtl/poly_sched_ctrl.sv
// Shared quadratic evaluator y = ((a*x)+b)*x + c in Horner form.
// Two round-robin arbitrated requesters share one add/mul ALU that runs one operation per cycle.
module poly_sched_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_sel,
  input  logic [W-1:0] cfg_data,
  output logic         cfg_busy,
  input  logic [W-1:0] x0,
  input  logic         x0_valid,
  output logic         x0_ready,
  input  logic [W-1:0] x1,
  input  logic         x1_valid,
  output logic         x1_ready,
  output logic [W-1:0] y,
  output logic         y_id,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C0   = 3'd1,
    C1   = 3'd2,
    C2   = 3'd3,
    C3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t         state;
  logic [W-1:0]   coef_a;
  logic [W-1:0]   coef_b;
  logic [W-1:0]   coef_c;
  logic [W-1:0]   t;
  logic [W-1:0]   x_lat;
  logic           id;
  logic           rr;

  logic           grant0;
  logic           grant1;
  logic           idle;
  logic [W-1:0]   op_l;
  logic [W-1:0]   op_r;
  logic           op_mul;
  logic [W-1:0]   alu;

  assign idle     = (state == IDLE);
  assign cfg_busy = ~idle;
  assign busy     = ~idle;

  // A lone requester always wins; on contention the round-robin pointer decides.
  assign grant0   = x0_valid & (~x1_valid | ~rr);
  assign grant1   = x1_valid & (~x0_valid |  rr);
  assign x0_ready = idle & grant0;
  assign x1_ready = idle & grant1;

  always_comb begin
    op_l   = '0;
    op_r   = '0;
    op_mul = 1'b0;
    case (state)
      C0: begin
        op_l   = coef_a;
        op_r   = x_lat;
        op_mul = 1'b1;
      end
      C1: begin
        op_l = t;
        op_r = coef_b;
      end
      C2: begin
        op_l   = t;
        op_r   = x_lat;
        op_mul = 1'b1;
      end
      C3: begin
        op_l = t;
        op_r = coef_c;
      end
      default: begin
        op_l   = '0;
        op_r   = '0;
        op_mul = 1'b0;
      end
    endcase
    // Results wrap modulo 2^W; the product is evaluated at W bits on purpose.
    alu = op_mul ? (op_l * op_r) : (op_l + op_r);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      coef_a  <= '0;
      coef_b  <= '0;
      coef_c  <= '0;
      t       <= '0;
      x_lat   <= '0;
      id      <= 1'b0;
      rr      <= 1'b0;
      y       <= '0;
      y_id    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Coefficient writes land before C0, so a same-cycle operand sees them.
          if (cfg_we) begin
            case (cfg_sel)
              2'd0:    coef_a <= cfg_data;
              2'd1:    coef_b <= cfg_data;
              2'd2:    coef_c <= cfg_data;
              default: ;
            endcase
          end
          if (x0_valid && x0_ready) begin
            x_lat <= x0;
            id    <= 1'b0;
            rr    <= 1'b1;
            state <= C0;
          end else if (x1_valid && x1_ready) begin
            x_lat <= x1;
            id    <= 1'b1;
            rr    <= 1'b0;
            state <= C0;
          end
        end
        C0: begin
          t     <= alu;
          state <= C1;
        end
        C1: begin
          t     <= alu;
          state <= C2;
        end
        C2: begin
          t     <= alu;
          state <= C3;
        end
        C3: begin
          y       <= alu;
          y_id    <= id;
          y_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (y_valid && y_ready) begin
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sched_ctrl.sv
// Scoreboard bench for poly_sched_ctrl: expected {id,y} queued at operand accept, popped at result handshake.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_poly_sched_ctrl;
  localparam int W   = 8;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_sel = '0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_busy;
  logic [W-1:0] x0 = '0;
  logic         x0_valid = 1'b0;
  logic         x0_ready;
  logic [W-1:0] x1 = '0;
  logic         x1_valid = 1'b0;
  logic         x1_ready;
  logic [W-1:0] y;
  logic         y_id;
  logic         y_valid;
  logic         y_ready = 1'b0;
  logic         busy;

  logic [8:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  poly_sched_ctrl #(.W(W)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
    .x0(x0), .x0_valid(x0_valid), .x0_ready(x0_ready),
    .x1(x1), .x1_valid(x1_valid), .x1_ready(x1_ready),
    .y(y), .y_id(y_id), .y_valid(y_valid), .y_ready(y_ready),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Offers one operand, queues its expected result on acceptance, returns just after the accept edge.
  task automatic submit(input logic rid, input logic [7:0] xv, input logic [7:0] ey, output logic ok);
    int cnt = 0;
    if (rid) begin x1 = xv; x1_valid = 1'b1; end
    else     begin x0 = xv; x0_valid = 1'b1; end
    #1;
    while (!(rid ? x1_ready : x0_ready) && cnt < 20) begin tick(); #1; cnt++; end
    ok = rid ? x1_ready : x0_ready;
    if (ok) exp_q.push_back({rid, ey});
    tick();
    x0_valid = 1'b0; x1_valid = 1'b0;
  endtask

  // Waits for y_valid, captures the result and completes the handshake; cyc = -1 on timeout.
  task automatic take_result(input int budget, output logic [7:0] gy, output logic gid, output int cyc);
    cyc = 0; gy = '0; gid = 1'b0;
    while (!y_valid && cyc < budget) begin tick(); cyc++; end
    if (!y_valid) cyc = -1;
    else begin
      gy = y; gid = y_id;
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_total++; if (y_valid !== 1'b0) $display("[TB] FAIL reset_y_valid: got %b expected 0", y_valid); else n_pass++;
    n_total++; if (y !== 8'h00) $display("[TB] FAIL reset_y: got %h expected 00", y); else n_pass++;
    n_total++; if (y_id !== 1'b0) $display("[TB] FAIL reset_y_id: got %b expected 0", y_id); else n_pass++;
    n_total++; if (busy !== 1'b0 || cfg_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", busy, cfg_busy); else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] gy; logic gid; int cyc;
    cfg_write(2'd0, 8'd2); cfg_write(2'd1, 8'd3); cfg_write(2'd2, 8'd5);
    x0 = 8'd4; x0_valid = 1'b1;
    #1;
    n_total++; if (x0_ready !== 1'b1 || x1_ready !== 1'b0) $display("[TB] FAIL basic_ready: got %b%b expected 10", x0_ready, x1_ready); else n_pass++;
    exp_q.push_back({1'b0, 8'h31});
    tick();
    x0_valid = 1'b0;
    #1;
    n_total++; if (busy !== 1'b1 || cfg_busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b/%b expected 1/1", busy, cfg_busy); else n_pass++;
    take_result(20, gy, gid, cyc);
    n_total++; if (cyc !== LAT) $display("[TB] FAIL basic_latency: got %0d expected %0d", cyc, LAT); else n_pass++;
    n_total++;
    if (cyc < 0 || exp_q.size() == 0) $display("[TB] FAIL basic_result: got none expected a result");
    else begin
      logic [8:0] e = exp_q.pop_front();
      if ({gid, gy} !== e) $display("[TB] FAIL basic_result: got %h expected %h", {gid, gy}, e); else n_pass++;
    end
    #1;
    n_total++; if (y_valid !== 1'b0 || y !== 8'h31) $display("[TB] FAIL basic_after_hs: got v=%b y=%h expected v=0 y=31", y_valid, y); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] gy; logic gid, ok; int cyc;
    logic [7:0] xs[2] = '{8'd255, 8'd16};
    logic [7:0] as[2] = '{8'd1, 8'd16};
    logic [7:0] bs[2] = '{8'd1, 8'd0};
    for (int k = 0; k < 2; k++) begin
      cfg_write(2'd0, as[k]); cfg_write(2'd1, bs[k]); cfg_write(2'd2, 8'd1);
      submit((k == 0), xs[k], 8'h01, ok);
      n_total++; if (ok !== 1'b1) $display("[TB] FAIL wrap_accept: got %b expected 1", ok); else n_pass++;
      take_result(20, gy, gid, cyc);
      n_total++;
      if (cyc < 0 || exp_q.size() == 0) $display("[TB] FAIL wrap_result: got none expected a result");
      else begin
        logic [8:0] e = exp_q.pop_front();
        if ({gid, gy} !== e) $display("[TB] FAIL wrap_result: got %h expected %h", {gid, gy}, e); else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] gy; logic gid, eid; int cyc, cnt;
    resetn = 1'b0; tick(); resetn = 1'b1;
    cfg_write(2'd1, 8'd1);
    x0 = 8'd1; x1 = 8'd2; x0_valid = 1'b1; x1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      eid = (k % 2 == 1);
      cnt = 0; #1;
      while (!(x0_ready || x1_ready) && cnt < 20) begin tick(); #1; cnt++; end
      n_total++; if (x0_ready === x1_ready) $display("[TB] FAIL rr_onehot: got %b%b expected one-hot", x0_ready, x1_ready); else n_pass++;
      n_total++; if (x1_ready !== eid) $display("[TB] FAIL rr_grant: got %b expected %b", x1_ready, eid); else n_pass++;
      exp_q.push_back({eid, eid ? 8'd2 : 8'd1});
      tick();
      take_result(20, gy, gid, cyc);
      n_total++;
      if (cyc < 0 || exp_q.size() == 0) $display("[TB] FAIL rr_result: got none expected a result");
      else begin
        logic [8:0] e = exp_q.pop_front();
        if ({gid, gy} !== e) $display("[TB] FAIL rr_result: got %h expected %h", {gid, gy}, e); else n_pass++;
      end
    end
    x0_valid = 1'b0; x1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] gy; logic gid, ok; int cyc;
    submit(1'b0, 8'd7, 8'd7, ok);
    x1 = 8'd9; x1_valid = 1'b1;
    cyc = 0;
    while (!y_valid && cyc < 20) begin tick(); cyc++; end
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++; if (y_valid !== 1'b1 || y !== 8'd7 || y_id !== 1'b0) $display("[TB] FAIL bp_hold: got v=%b y=%h id=%b expected v=1 y=07 id=0", y_valid, y, y_id); else n_pass++;
      n_total++; if (x0_ready !== 1'b0 || x1_ready !== 1'b0) $display("[TB] FAIL bp_ready: got %b%b expected 00", x0_ready, x1_ready); else n_pass++;
      tick();
    end
    n_total++;
    if (!y_valid || exp_q.size() == 0) $display("[TB] FAIL bp_result: got none expected a result");
    else begin
      logic [8:0] e = exp_q.pop_front();
      if ({y_id, y} !== e) $display("[TB] FAIL bp_result: got %h expected %h", {y_id, y}, e); else n_pass++;
    end
    y_ready = 1'b1; tick(); y_ready = 1'b0;
    #1;
    n_total++; if (y_valid !== 1'b0 || x1_ready !== 1'b1) $display("[TB] FAIL bp_release: got v=%b x1_ready=%b expected v=0 x1_ready=1", y_valid, x1_ready); else n_pass++;
    exp_q.push_back({1'b1, 8'd9});
    tick();
    x1_valid = 1'b0;
    take_result(20, gy, gid, cyc);
    n_total++; if (cyc !== LAT) $display("[TB] FAIL bp_latency: got %0d expected %0d", cyc, LAT); else n_pass++;
    n_total++;
    if (cyc < 0 || exp_q.size() == 0) $display("[TB] FAIL bp_second: got none expected a result");
    else begin
      logic [8:0] e = exp_q.pop_front();
      if ({gid, gy} !== e) $display("[TB] FAIL bp_second: got %h expected %h", {gid, gy}, e); else n_pass++;
    end
  endtask

  task automatic test_cfg_busy();
    logic [7:0] gy; logic gid, ok; int cyc;
    logic [7:0] xs[3] = '{8'd2, 8'd1, 8'd5};
    logic [7:0] ys[3] = '{8'd14, 8'd4, 8'h60};
    cfg_write(2'd0, 8'd3);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) cfg_write(2'd3, 8'h77);
      if (k == 2) begin cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 8'h10; end
      submit((k == 2), xs[k], ys[k], ok);
      cfg_we = 1'b0;
      if (k == 0) begin
        tick();
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd9;
        #1;
        n_total++; if (cfg_busy !== 1'b1) $display("[TB] FAIL cfg_busy_flag: got %b expected 1", cfg_busy); else n_pass++;
        tick();
        cfg_we = 1'b0;
      end
      take_result(20, gy, gid, cyc);
      n_total++;
      if (cyc < 0 || exp_q.size() == 0) $display("[TB] FAIL cfg_result: got none expected a result");
      else begin
        logic [8:0] e = exp_q.pop_front();
        if ({gid, gy} !== e) $display("[TB] FAIL cfg_result: got %h expected %h", {gid, gy}, e); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] gy; logic gid, ok; int cyc;
    x0 = 8'd3; x0_valid = 1'b1;
    tick();
    x0_valid = 1'b0;
    tick(); tick();
    resetn = 1'b0; tick(); resetn = 1'b1;
    #1;
    n_total++; if (y_valid !== 1'b0 || y !== 8'h00 || busy !== 1'b0) $display("[TB] FAIL midop_reset: got v=%b y=%h busy=%b expected 0/00/0", y_valid, y, busy); else n_pass++;
    submit(1'b1, 8'h5A, 8'h00, ok);
    take_result(20, gy, gid, cyc);
    n_total++;
    if (cyc < 0 || exp_q.size() == 0) $display("[TB] FAIL midop_result: got none expected a result");
    else begin
      logic [8:0] e = exp_q.pop_front();
      if ({gid, gy} !== e) $display("[TB] FAIL midop_result: got %h expected %h", {gid, gy}, e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_cfg_busy();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
